microc_ctrl: RTL and testbench

MICROC_CTRL -- requirements
Module: microc_ctrl

---
 rtl/microc_pkg.sv | 44 ++++
 rtl/microc_decode.sv | 43 ++++
 rtl/microc_ctrl.sv | 121 ++++++++++++
 tb/tb_microc_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/microc_pkg.sv
// Shared constants and types for the microc controller: opcodes, ALU ops,
// FSM state encoding and the decoded control word.
package microc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  localparam logic [5:0] OP_J    = 6'b000000;
  localparam logic [5:0] OP_JZ   = 6'b000001;
  localparam logic [5:0] OP_JNZ  = 6'b000010;
  localparam logic [5:0] OP_NOP  = 6'b000011;
  localparam logic [5:0] OP_LI   = 6'b000100;
  localparam logic [5:0] OP_ILL0 = 6'b000101;
  localparam logic [5:0] OP_ILL1 = 6'b000110;
  localparam logic [5:0] OP_HALT = 6'b000111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;

  typedef struct packed {
    logic       s_inc;
    logic       s_inm;
    logic       we;
    logic       wez;
    logic [2:0] alu_op;
  } ctrl_word_t;

  // Control word of a cycle that must not disturb the datapath.
  localparam ctrl_word_t CTRL_IDLE = '{
    s_inc:  1'b1,
    s_inm:  1'b0,
    we:     1'b0,
    wez:    1'b0,
    alu_op: ALU_ADD
  };

endpackage

// File: rtl/microc_decode.sv
// Purely combinational opcode decoder: raw control word plus illegal/halt
// flags. Gating by FSM state is done by the caller.
module microc_decode
  import microc_pkg::*;
(
  input  logic [5:0] Opcode,
  input  logic       z,
  output ctrl_word_t ctrl,
  output logic       illegal,
  output logic       is_halt
);

  always_comb begin
    ctrl    = CTRL_IDLE;
    illegal = 1'b0;
    is_halt = 1'b0;
    if (Opcode[5]) begin
      ctrl.we     = 1'b1;
      ctrl.wez    = 1'b1;
      ctrl.s_inm  = 1'b1;
      ctrl.alu_op = Opcode[4:2];
    end else if (Opcode[4]) begin
      ctrl.we     = 1'b1;
      ctrl.wez    = 1'b1;
      ctrl.alu_op = Opcode[3:1];
    end else begin
      unique case (Opcode)
        OP_J:   ctrl.s_inc = 1'b0;
        OP_JZ:  ctrl.s_inc = ~z;
        OP_JNZ: ctrl.s_inc = z;
        OP_NOP: ;
        OP_LI: begin
          ctrl.we    = 1'b1;
          ctrl.s_inm = 1'b1;
        end
        OP_ILL0, OP_ILL1: illegal = 1'b1;
        OP_HALT: is_halt = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/microc_ctrl.sv
// microc controller: IDLE/RUN/STEP/HALT sequencing, execute gating of the
// decoded control word, sticky illegal-opcode flag and instruction counter.
module microc_ctrl
  import microc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  Opcode,
  input  logic        z,
  input  logic        start,
  input  logic        step_mode,
  input  logic        step,
  input  logic        halt_req,
  output logic        s_inc,
  output logic        s_inm,
  output logic        we,
  output logic        wez,
  output logic [2:0]  ALUOp,
  output logic        pc_en,
  output logic        running,
  output logic        halted,
  output logic        err,
  output logic [15:0] icount
);

  state_t     state;
  state_t     state_nxt;
  ctrl_word_t dec_ctrl;
  logic       dec_illegal;
  logic       dec_halt;
  logic       exec;

  microc_decode u_decode (
    .Opcode  (Opcode),
    .z       (z),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal),
    .is_halt (dec_halt)
  );

  // Reset is folded in so a cycle with reset asserted never counts or flags.
  always_comb begin
    exec = 1'b0;
    if (reset && !halt_req && !dec_halt) begin
      exec = (state == ST_RUN) || ((state == ST_STEP) && step);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = step_mode ? ST_STEP : ST_RUN;
        end
      end
      ST_RUN: begin
        if (halt_req) begin
          state_nxt = ST_IDLE;
        end else if (dec_halt) begin
          state_nxt = ST_HALT;
        end else if (step_mode) begin
          state_nxt = ST_STEP;
        end
      end
      ST_STEP: begin
        if (halt_req) begin
          state_nxt = ST_IDLE;
        end else if (step && dec_halt) begin
          state_nxt = ST_HALT;
        end else if (!step_mode) begin
          state_nxt = ST_RUN;
        end
      end
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    s_inc   = CTRL_IDLE.s_inc;
    s_inm   = CTRL_IDLE.s_inm;
    we      = CTRL_IDLE.we;
    wez     = CTRL_IDLE.wez;
    ALUOp   = CTRL_IDLE.alu_op;
    pc_en   = 1'b0;
    running = (state == ST_RUN);
    halted  = (state == ST_HALT);
    if (exec) begin
      s_inc = dec_ctrl.s_inc;
      s_inm = dec_ctrl.s_inm;
      we    = dec_ctrl.we;
      wez   = dec_ctrl.wez;
      ALUOp = dec_ctrl.alu_op;
      pc_en = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      err    <= 1'b0;
      icount <= '0;
    end else begin
      if (exec && dec_illegal) begin
        err <= 1'b1;
      end
      if (pc_en && (icount != '1)) begin
        icount <= icount + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_microc_ctrl.sv
// Self-checking bench for microc_ctrl: directed scenarios plus randomized
// traffic, all compared every cycle against a behavioural model.
module tb_microc_ctrl;

  logic        clk;
  logic        reset;
  logic [5:0]  Opcode;
  logic        z;
  logic        start;
  logic        step_mode;
  logic        step;
  logic        halt_req;
  logic        s_inc;
  logic        s_inm;
  logic        we;
  logic        wez;
  logic [2:0]  ALUOp;
  logic        pc_en;
  logic        running;
  logic        halted;
  logic        err;
  logic [15:0] icount;

  microc_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .Opcode    (Opcode),
    .z         (z),
    .start     (start),
    .step_mode (step_mode),
    .step      (step),
    .halt_req  (halt_req),
    .s_inc     (s_inc),
    .s_inm     (s_inm),
    .we        (we),
    .wez       (wez),
    .ALUOp     (ALUOp),
    .pc_en     (pc_en),
    .running   (running),
    .halted    (halted),
    .err       (err),
    .icount    (icount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  // Model: mode 0=idle 1=run 2=step 3=halt
  int m_mode   = 0;
  int m_icount = 0;
  bit m_err    = 1'b0;
  bit m_valid  = 1'b0;

  logic snap_s_inc, snap_we, snap_pc_en, snap_running, snap_halted;
  int   pe_cnt;

  // {s_inc, s_inm, we, wez, ALUOp} expected for an executing cycle.
  function automatic logic [6:0] expect_word(input int op, input bit zz);
    if (op >= 32) return {4'b1111, 3'((op / 4) % 8)};
    if (op >= 16) return {4'b1011, 3'((op / 2) % 8)};
    case (op)
      0:       return 7'b0000000;
      1:       return {~zz, 6'b0};
      2:       return {zz, 6'b0};
      4:       return 7'b1110000;
      default: return 7'b1000000;
    endcase
  endfunction

  task automatic pin(input string name, input int got, input int expv);
    tests++;
    if (got != expv) begin
      failed++;
      $display("FAIL %s got=%0d expected=%0d", name, got, expv);
    end
  endtask

  task automatic cyc(input int op, input bit zz, input bit st, input bit sm,
                     input bit sp, input bit hr, input bit rst);
    bit          ex;
    logic [6:0]  w;
    logic [26:0] got, expv;
    Opcode = 6'(op); z = zz; start = st; step_mode = sm;
    step = sp; halt_req = hr; reset = rst;
    #3;
    ex = rst && !hr && (op != 7) && ((m_mode == 1) || (m_mode == 2 && sp));
    w  = ex ? expect_word(op, zz) : 7'b1000000;
    if (m_valid) begin
      got  = {s_inc, s_inm, we, wez, ALUOp, pc_en, running, halted, err, icount};
      expv = {w, ex, (m_mode == 1), (m_mode == 3), m_err, 16'(m_icount)};
      tests++;
      if (got !== expv) begin
        failed++;
        $display("FAIL cycle_outputs t=%0t op=%0d got=%h expected=%h", $time, op, got, expv);
      end
    end
    snap_s_inc = s_inc; snap_we = we; snap_pc_en = pc_en;
    snap_running = running; snap_halted = halted;
    if (pc_en === 1'b1) pe_cnt++;
    if (!rst) begin
      m_mode = 0; m_icount = 0; m_err = 1'b0; m_valid = 1'b1;
    end else if (m_valid) begin
      if (ex) begin
        if (m_icount < 65535) m_icount++;
        if (op == 5 || op == 6) m_err = 1'b1;
      end
      case (m_mode)
        0: if (st) m_mode = sm ? 2 : 1;
        1: if (hr) m_mode = 0; else if (op == 7) m_mode = 3; else if (sm) m_mode = 2;
        2: if (hr) m_mode = 0; else if (sp && op == 7) m_mode = 3; else if (!sm) m_mode = 1;
        default: ;
      endcase
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    cyc(3, 0, 0, 0, 0, 0, 0);
    cyc(3, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int op, r;
    bit sm;

    // Reset, then start in free-run mode
    do_reset();
    cyc(3, 0, 0, 0, 0, 0, 1);
    pin("reset_running", int'(snap_running), 0);
    pin("reset_icount", int'(icount), 0);
    cyc(3, 0, 1, 0, 0, 0, 1);
    cyc(4, 0, 0, 0, 0, 0, 1);
    pin("start_running", int'(snap_running), 1);
    cyc(4, 0, 0, 0, 0, 0, 1);
    cyc(22, 0, 0, 0, 0, 0, 1);
    cyc(2, 0, 0, 0, 0, 0, 1);
    pin("jnz_z0_s_inc", int'(snap_s_inc), 0);
    pin("prog_icount", int'(icount), 4);
    cyc(2, 1, 0, 0, 0, 0, 1);
    pin("jnz_z1_s_inc", int'(snap_s_inc), 1);

    // HALT opcode in RUN; HALT ignores start/step/halt_req
    cyc(7, 0, 0, 0, 0, 0, 1);
    pin("halt_op_pc_en", int'(snap_pc_en), 0);
    pe_cnt = 0;
    cyc(7, 0, 1, 0, 1, 0, 1);
    cyc(3, 0, 1, 1, 1, 1, 1);
    cyc(3, 0, 1, 0, 0, 0, 1);
    pin("halt_sticky", int'(snap_halted), 1);
    pin("halt_pc_en_cnt", pe_cnt, 0);

    // Single step: three pulses five cycles apart
    do_reset();
    cyc(3, 0, 1, 1, 0, 0, 1);
    pe_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      cyc(3, 0, 0, 1, 1, 0, 1);
      for (int j = 0; j < 4; j++) cyc(4, 0, 0, 1, 0, 0, 1);
    end
    pin("step_pc_en_cnt", pe_cnt, 3);
    pin("step_icount", int'(icount), 3);

    // halt_req during ADDI, then an illegal opcode
    do_reset();
    cyc(3, 0, 1, 0, 0, 0, 1);
    cyc(32, 0, 0, 0, 0, 1, 1);
    pin("haltreq_we", int'(snap_we), 0);
    pin("haltreq_pc_en", int'(snap_pc_en), 0);
    cyc(3, 0, 0, 0, 0, 0, 1);
    pin("haltreq_running", int'(snap_running), 0);
    cyc(3, 0, 1, 0, 0, 0, 1);
    cyc(5, 0, 0, 0, 0, 0, 1);
    pin("illegal_pc_en", int'(snap_pc_en), 1);
    cyc(3, 0, 0, 0, 0, 0, 1);
    cyc(6, 0, 0, 0, 0, 1, 1);
    pin("err_held", int'(err), 1);

    // Counter saturation, then reset mid-run
    do_reset();
    cyc(3, 0, 1, 0, 0, 0, 1);
    for (int k = 0; k < 65540; k++) cyc(3, 0, 0, 0, 0, 0, 1);
    pin("icount_sat", int'(icount), 65535);
    cyc(16, 1, 0, 0, 0, 0, 0);
    pin("midrun_icount", int'(icount), 0);
    cyc(3, 0, 0, 0, 0, 0, 1);
    pin("midrun_running", int'(snap_running), 0);

    // Randomized traffic
    sm = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      r = int'($urandom_range(0, 99));
      if      (r < 40) op = int'($urandom_range(32, 63));
      else if (r < 60) op = int'($urandom_range(16, 31));
      else if (r < 80) op = int'($urandom_range(0, 4));
      else if (r < 86) op = int'($urandom_range(5, 6));
      else if (r < 88) op = 7;
      else             op = 3;
      if ($urandom_range(0, 19) == 0) sm = ~sm;
      cyc(op, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), sm,
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 19) == 0),
          ($urandom_range(0, 49) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
